// File: rtl/spart_driver.sv
// Processor-side bus master for the SPART: programs the baud divisor after reset or a
// baud-switch change, then echoes every received byte back to the transmit buffer.
module spart_driver #(
    parameter logic [15:0] DIV0 = 16'd650,
    parameter logic [15:0] DIV1 = 16'd325,
    parameter logic [15:0] DIV2 = 16'd162,
    parameter logic [15:0] DIV3 = 16'd80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] last_rx
);

    typedef enum logic [2:0] {
        StLoadLo,
        StLoadHi,
        StIdle,
        StRead,
        StWaitTbr,
        StWrite
    } state_e;

    state_e      state;
    logic [1:0]  cfg_shadow;
    logic [7:0]  held;
    logic [7:0]  dout;
    logic [15:0] div;

    always_comb begin
        div = DIV0;
        unique case (cfg_shadow)
            2'b00: div = DIV0;
            2'b01: div = DIV1;
            2'b10: div = DIV2;
            2'b11: div = DIV3;
        endcase
    end

    // Bus enable comes straight from the registered strobe, so it never glitches.
    assign databus = (iocs && !iorw) ? dout : 8'bz;

    // state names the access to issue next; the strobe registers show it one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StLoadLo;
            iocs       <= 1'b0;
            iorw       <= 1'b1;
            ioaddr     <= 2'b00;
            dout       <= 8'h00;
            last_rx    <= 8'h00;
            held       <= 8'h00;
            cfg_shadow <= br_cfg;
        end else begin
            // A read strobe that was on the bus this cycle closes on this edge.
            if (iocs && iorw) begin
                held    <= databus;
                last_rx <= databus;
            end

            iocs   <= 1'b0;
            iorw   <= 1'b1;
            ioaddr <= 2'b00;
            dout   <= 8'h00;

            case (state)
                StLoadLo: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= 2'b10;
                    dout   <= div[7:0];
                    state  <= StLoadHi;
                end
                StLoadHi: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= 2'b11;
                    dout   <= div[15:8];
                    state  <= StIdle;
                end
                StIdle: begin
                    if (br_cfg != cfg_shadow) begin
                        cfg_shadow <= br_cfg;
                        state      <= StLoadLo;
                    end else if (rda) begin
                        state <= StRead;
                    end
                end
                StRead: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b1;
                    ioaddr <= 2'b00;
                    state  <= StWaitTbr;
                end
                StWaitTbr: begin
                    if (tbr) begin
                        state <= StWrite;
                    end
                end
                StWrite: begin
                    iocs   <= 1'b1;
                    iorw   <= 1'b0;
                    ioaddr <= 2'b00;
                    dout   <= held;
                    state  <= StIdle;
                end
                default: state <= StLoadLo;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a small SPART model plus an expected-access list checked every cycle,
// with literal timing checks for the load, echo, deferred-reload and reset scenarios.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] last_rx;

    always #5 clk = ~clk;

    spart_driver dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .rda     (rda),
        .tbr     (tbr),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .last_rx (last_rx)
    );

    // SPART receive side: bytes offered by the stimulus, consumed by read accesses.
    logic [7:0] rx_bytes [0:15];
    int         offered = 0;
    int         consumed = 0;
    wire        spart_oe = iocs && iorw && (ioaddr == 2'b00);

    assign databus = spart_oe ? rx_bytes[consumed[3:0]] : 8'bz;
    assign rda     = (offered != consumed);

    always @(posedge clk) begin
        if (spart_oe) consumed <= consumed + 1;
    end

    logic rst_q;
    always @(posedge clk) rst_q <= rst;

    // Expected bus accesses, in order.
    logic       exp_rw   [0:31];
    logic [1:0] exp_addr [0:31];
    logic [7:0] exp_data [0:31];
    int         exp_wr = 0;
    int         exp_rd = 0;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] pend = 8'h00;
    logic       pend_v = 1'b0;
    logic       prev_iocs = 1'b0;
    logic       prev_lo = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_acc(input logic rw, input logic [1:0] addr, input logic [7:0] data);
        exp_rw[exp_wr]   = rw;
        exp_addr[exp_wr] = addr;
        exp_data[exp_wr] = data;
        exp_wr++;
    endtask

    task automatic offer(input logic [7:0] b);
        rx_bytes[offered[3:0]] = b;
        offered++;
    endtask

    task automatic cycle_check();
        if (rst_q) begin
            chk("reset_outputs", {iocs, iorw, ioaddr, last_rx}, {1'b0, 1'b1, 2'b00, 8'h00});
            m_last    = 8'h00;
            pend_v    = 1'b0;
            prev_iocs = 1'b0;
            prev_lo   = 1'b0;
        end else begin
            chk("no_x_on_ctrl", 32'($isunknown({iocs, iorw, ioaddr})), 0);
            if (pend_v) begin
                m_last = pend;
                pend_v = 1'b0;
            end
            chk("last_rx", last_rx, m_last);
            if (iocs) begin
                if (prev_iocs) chk("strobe_back_to_back", prev_lo, 1);
                chk("access_expected", 32'(exp_wr > exp_rd), 1);
                if (exp_wr > exp_rd) begin
                    chk("access_kind", {iorw, ioaddr}, {exp_rw[exp_rd], exp_addr[exp_rd]});
                    if (!exp_rw[exp_rd]) begin
                        chk("write_data", databus, exp_data[exp_rd]);
                    end else begin
                        pend   = exp_data[exp_rd];
                        pend_v = 1'b1;
                    end
                    exp_rd++;
                end
            end
            prev_iocs = iocs;
            prev_lo   = iocs && !iorw && (ioaddr == 2'b10);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input logic rw, input logic [1:0] addr, input string name);
        int n;
        n = 0;
        while (!(iocs && iorw == rw && ioaddr == addr) && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(iocs && iorw == rw && ioaddr == addr), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rx_bytes[i] = 8'h00;
        rst    = 1'b1;
        br_cfg = 2'b01;
        tbr    = 1'b1;
        tick();
        tick();
        tick();

        // Divisor load after reset, br_cfg = 01 (325 = 0x0145).
        expect_acc(1'b0, 2'b10, 8'h45);
        expect_acc(1'b0, 2'b11, 8'h01);
        rst = 1'b0;
        tick();
        chk("load_lo", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b10, 8'h45});
        tick();
        chk("load_hi", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b11, 8'h01});
        tick();
        chk("idle_after_load", {iocs, iorw}, 2'b01);

        // Single echo with tbr already high.
        offer(8'hA5);
        expect_acc(1'b1, 2'b00, 8'hA5);
        expect_acc(1'b0, 2'b00, 8'hA5);
        tick();
        chk("idle_at_k", iocs, 0);
        tick();
        chk("read_strobe_k1", {iocs, iorw, ioaddr}, {1'b1, 1'b1, 2'b00});
        tick();
        chk("wait_tbr_k2", {iocs, last_rx}, {1'b0, 8'hA5});
        tick();
        chk("write_strobe_k3", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b00, 8'hA5});
        tick();
        chk("idle_k4", iocs, 0);

        // Two bytes queued, tbr low for 100 cycles after the first read.
        tbr = 1'b0;
        offer(8'hE7);
        offer(8'h24);
        expect_acc(1'b1, 2'b00, 8'hE7);
        expect_acc(1'b0, 2'b00, 8'hE7);
        expect_acc(1'b1, 2'b00, 8'h24);
        expect_acc(1'b0, 2'b00, 8'h24);
        wait_strobe(1'b1, 2'b00, "read_e7");
        repeat (100) tick();
        chk("held_while_tbr_low", {iocs, last_rx}, {1'b0, 8'hE7});
        tbr = 1'b1;
        wait_strobe(1'b0, 2'b00, "write_e7");
        chk("write_e7_data", databus, 8'hE7);
        tick();
        wait_strobe(1'b1, 2'b00, "read_24");
        wait_strobe(1'b0, 2'b00, "write_24");
        chk("write_24_data", databus, 8'h24);
        tick();
        tick();

        // Baud change during WAIT_TBR is deferred until the echo completes (80 = 0x0050).
        tbr = 1'b0;
        offer(8'h3C);
        expect_acc(1'b1, 2'b00, 8'h3C);
        expect_acc(1'b0, 2'b00, 8'h3C);
        expect_acc(1'b0, 2'b10, 8'h50);
        expect_acc(1'b0, 2'b11, 8'h00);
        wait_strobe(1'b1, 2'b00, "read_3c");
        tick();
        tick();
        br_cfg = 2'b11;
        repeat (3) tick();
        chk("no_reload_during_echo", iocs, 0);
        tbr = 1'b1;
        wait_strobe(1'b0, 2'b00, "write_3c");
        chk("write_3c_data", databus, 8'h3C);
        tick();
        chk("idle_before_reload", iocs, 0);
        tick();
        chk("reload_lo", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b10, 8'h50});
        tick();
        chk("reload_hi", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b11, 8'h00});
        tick();

        // Reset asserted during a WRITE strobe.
        offer(8'h81);
        expect_acc(1'b1, 2'b00, 8'h81);
        expect_acc(1'b0, 2'b00, 8'h81);
        wait_strobe(1'b1, 2'b00, "read_81");
        wait_strobe(1'b0, 2'b00, "write_81");
        rst = 1'b1;
        expect_acc(1'b0, 2'b10, 8'h50);
        expect_acc(1'b0, 2'b11, 8'h00);
        tick();
        chk("reset_mid_write", {iocs, iorw, last_rx}, {1'b0, 1'b1, 8'h00});
        rst = 1'b0;
        tick();
        chk("reset_reload_lo", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b10, 8'h50});
        tick();
        chk("reset_reload_hi", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b11, 8'h00});
        repeat (4) tick();
        chk("all_expected_seen", exp_rd, exp_wr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
